// File: rtl/coord_gen_if.sv
// Bus between the raster coordinate generator and its host / Divider side.
interface coord_gen_if;
  logic       start;
  logic [6:0] src_w;
  logic [6:0] src_h;
  logic [6:0] dst_w;
  logic [6:0] dst_h;
  logic [2:0] cycle_cnt;
  logic [6:0] x_int;
  logic [6:0] y_int;
  logic [6:0] x_rem;
  logic [6:0] y_rem;
  logic [6:0] x_den;
  logic [6:0] y_den;
  logic       slot_valid;
  logic       last;
  logic       busy;
  logic       done;
  logic       cfg_err;

  // Host side: requests frames, observes coordinates
  modport master (
    output start, src_w, src_h, dst_w, dst_h,
    input  cycle_cnt, x_int, y_int, x_rem, y_rem, x_den, y_den,
    input  slot_valid, last, busy, done, cfg_err
  );

  // Generator side
  modport slave (
    input  start, src_w, src_h, dst_w, dst_h,
    output cycle_cnt, x_int, y_int, x_rem, y_rem, x_den, y_den,
    output slot_valid, last, busy, done, cfg_err
  );
endinterface

// File: rtl/coord_gen.sv
// Raster coordinate generator: one destination pixel per 8-cycle slot, source
// coordinate as integer part plus remainder/denominator for Divider.
module coord_gen (
  input  logic       clk,
  input  logic       rst,
  coord_gen_if.slave bus
);

  localparam int unsigned W  = 7;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 10;
  localparam int unsigned PW = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  sw_q, sw_d, sh_q, sh_d, dw_q, dw_d, dh_q, dh_d;
  logic [W-1:0]  xd_q, xd_d, yd_q, yd_d;
  logic [AW-1:0] nx_acc_q, nx_acc_d, ny_acc_q, ny_acc_d;
  logic [W-1:0]  nx_int_q, nx_int_d, ny_int_q, ny_int_d;
  logic [PW-1:0] cycle_q, cycle_d;
  logic [W-1:0]  x_int_q, x_int_d, y_int_q, y_int_d;
  logic [W-1:0]  x_rem_q, x_rem_d, y_rem_q, y_rem_d;
  logic [W-1:0]  x_den_q, x_den_d, y_den_q, y_den_d;
  logic          valid_q, valid_d, last_q, last_d;
  logic          busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;

  logic          cfg_ok_c;
  logic          row_end_c;
  logic          x_ge_c, y_ge_c;
  logic [AW-1:0] nx_acc_step_c, ny_acc_step_c;
  logic [W-1:0]  nx_int_step_c, ny_int_step_c;
  logic [W-1:0]  xd_adv_c, yd_adv_c;

  // Legality of a requested frame: sizes >= 2 and at most 7 subtracts per step
  assign cfg_ok_c = (bus.src_w >= 7'd2) && (bus.src_h >= 7'd2) &&
                    (bus.dst_w >= 7'd2) && (bus.dst_h >= 7'd2) &&
                    ((CW'(bus.src_w) - CW'(1)) <= (CW'(bus.dst_w - 7'd1) * CW'(7))) &&
                    ((CW'(bus.src_h) - CW'(1)) <= (CW'(bus.dst_h - 7'd1) * CW'(7)));

  // One conditional-subtract step of the shadow accumulators
  assign x_ge_c        = (nx_acc_q >= AW'(x_den_q));
  assign y_ge_c        = (ny_acc_q >= AW'(y_den_q));
  assign nx_acc_step_c = x_ge_c ? (nx_acc_q - AW'(x_den_q)) : nx_acc_q;
  assign ny_acc_step_c = y_ge_c ? (ny_acc_q - AW'(y_den_q)) : ny_acc_q;
  assign nx_int_step_c = x_ge_c ? (nx_int_q + 7'd1) : nx_int_q;
  assign ny_int_step_c = y_ge_c ? (ny_int_q + 7'd1) : ny_int_q;

  // Raster position of the next slot
  assign row_end_c = (xd_q == (dw_q - 7'd1));
  assign xd_adv_c  = row_end_c ? 7'd0 : (xd_q + 7'd1);
  assign yd_adv_c  = row_end_c ? (yd_q + 7'd1) : yd_q;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    sw_d      = sw_q;
    sh_d      = sh_q;
    dw_d      = dw_q;
    dh_d      = dh_q;
    xd_d      = xd_q;
    yd_d      = yd_q;
    nx_acc_d  = nx_acc_q;
    ny_acc_d  = ny_acc_q;
    nx_int_d  = nx_int_q;
    ny_int_d  = ny_int_q;
    cycle_d   = cycle_q;
    x_int_d   = x_int_q;
    y_int_d   = y_int_q;
    x_rem_d   = x_rem_q;
    y_rem_d   = y_rem_q;
    x_den_d   = x_den_q;
    y_den_d   = y_den_q;
    valid_d   = valid_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (cfg_ok_c) begin
            state_d  = ST_RUN;
            sw_d     = bus.src_w;
            sh_d     = bus.src_h;
            dw_d     = bus.dst_w;
            dh_d     = bus.dst_h;
            xd_d     = '0;
            yd_d     = '0;
            nx_acc_d = '0;
            ny_acc_d = '0;
            nx_int_d = '0;
            ny_int_d = '0;
            cycle_d  = '0;
            x_int_d  = '0;
            y_int_d  = '0;
            x_rem_d  = '0;
            y_rem_d  = '0;
            x_den_d  = bus.dst_w - 7'd1;
            y_den_d  = bus.dst_h - 7'd1;
            valid_d  = 1'b1;
            last_d   = 1'b0;
            busy_d   = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        cycle_d = cycle_q + 3'd1;
        if (cycle_q == 3'd0) begin
          // Seed the shadow with current remainder plus one step
          if (row_end_c) begin
            nx_acc_d = '0;
            nx_int_d = '0;
            ny_acc_d = AW'(y_rem_q) + AW'(sh_q - 7'd1);
            ny_int_d = y_int_q;
          end else begin
            nx_acc_d = AW'(x_rem_q) + AW'(sw_q - 7'd1);
            nx_int_d = x_int_q;
            ny_acc_d = AW'(y_rem_q);
            ny_int_d = y_int_q;
          end
        end else begin
          nx_acc_d = nx_acc_step_c;
          ny_acc_d = ny_acc_step_c;
          nx_int_d = nx_int_step_c;
          ny_int_d = ny_int_step_c;
          if (cycle_q == 3'd7) begin
            if (last_q) begin
              // Final slot: coordinates keep their last values
              state_d = ST_DONE;
              cycle_d = '0;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              last_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              x_rem_d = W'(nx_acc_step_c);
              y_rem_d = W'(ny_acc_step_c);
              x_int_d = nx_int_step_c;
              y_int_d = ny_int_step_c;
              xd_d    = xd_adv_c;
              yd_d    = yd_adv_c;
              last_d  = (xd_adv_c == (dw_q - 7'd1)) && (yd_adv_c == (dh_q - 7'd1));
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sw_q      <= '0;
      sh_q      <= '0;
      dw_q      <= '0;
      dh_q      <= '0;
      xd_q      <= '0;
      yd_q      <= '0;
      nx_acc_q  <= '0;
      ny_acc_q  <= '0;
      nx_int_q  <= '0;
      ny_int_q  <= '0;
      cycle_q   <= '0;
      x_int_q   <= '0;
      y_int_q   <= '0;
      x_rem_q   <= '0;
      y_rem_q   <= '0;
      x_den_q   <= '0;
      y_den_q   <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sw_q      <= sw_d;
      sh_q      <= sh_d;
      dw_q      <= dw_d;
      dh_q      <= dh_d;
      xd_q      <= xd_d;
      yd_q      <= yd_d;
      nx_acc_q  <= nx_acc_d;
      ny_acc_q  <= ny_acc_d;
      nx_int_q  <= nx_int_d;
      ny_int_q  <= ny_int_d;
      cycle_q   <= cycle_d;
      x_int_q   <= x_int_d;
      y_int_q   <= y_int_d;
      x_rem_q   <= x_rem_d;
      y_rem_q   <= y_rem_d;
      x_den_q   <= x_den_d;
      y_den_q   <= y_den_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.cycle_cnt  = cycle_q;
  assign bus.x_int      = x_int_q;
  assign bus.y_int      = y_int_q;
  assign bus.x_rem      = x_rem_q;
  assign bus.y_rem      = y_rem_q;
  assign bus.x_den      = x_den_q;
  assign bus.y_den      = y_den_q;
  assign bus.slot_valid = valid_q;
  assign bus.last       = last_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_coord_gen.sv
// Bench for coord_gen: directed frames from the test plan plus random legal
// and illegal configurations, compared against an arithmetic pixel model.
module tb_coord_gen;

  logic clk;
  logic rst;
  coord_gen_if bus ();

  coord_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks;
  int n_errors;

  // Values the coordinate outputs are expected to hold while idle
  int h_xi, h_xr, h_yi, h_yr, h_xd, h_yd;

  // Per-slot observed coordinates (first 256 slots of the latest frame)
  int obs_xi [256];
  int obs_xr [256];
  int obs_yi [256];
  int obs_yr [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic expect_all(input string tag, input int cyc, input int xi, input int xr,
                            input int yi, input int yr, input int xden, input int yden,
                            input int vld, input int bsy, input int lst, input int dn,
                            input int ce);
    check({tag, ".cycle_cnt"},  int'(bus.cycle_cnt),  cyc);
    check({tag, ".x_int"},      int'(bus.x_int),      xi);
    check({tag, ".x_rem"},      int'(bus.x_rem),      xr);
    check({tag, ".y_int"},      int'(bus.y_int),      yi);
    check({tag, ".y_rem"},      int'(bus.y_rem),      yr);
    check({tag, ".x_den"},      int'(bus.x_den),      xden);
    check({tag, ".y_den"},      int'(bus.y_den),      yden);
    check({tag, ".slot_valid"}, int'(bus.slot_valid), vld);
    check({tag, ".busy"},       int'(bus.busy),       bsy);
    check({tag, ".last"},       int'(bus.last),       lst);
    check({tag, ".done"},       int'(bus.done),       dn);
    check({tag, ".cfg_err"},    int'(bus.cfg_err),    ce);
  endtask

  task automatic set_cfg(input int sw, input int sh, input int dw, input int dh);
    bus.src_w = 7'(sw);
    bus.src_h = 7'(sh);
    bus.dst_w = 7'(dw);
    bus.dst_h = 7'(dh);
  endtask

  // Full frame; poke >= 0 asserts start at that cycle index while busy,
  // start_on_done asserts a legal start during the done cycle.
  task automatic run_frame(input int sw, input int sh, input int dw, input int dh,
                           input int poke, input bit start_on_done);
    int n, xd, yd, xi, xr, yi, yr;
    n = dw * dh;
    @(negedge clk);
    set_cfg(sw, sh, dw, dh);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < n; k++) begin
      xd = k % dw;
      yd = k / dw;
      xi = (xd * (sw - 1)) / (dw - 1);
      xr = (xd * (sw - 1)) % (dw - 1);
      yi = (yd * (sh - 1)) / (dh - 1);
      yr = (yd * (sh - 1)) % (dh - 1);
      for (int c = 0; c < 8; c++) begin
        expect_all("slot", c, xi, xr, yi, yr, dw - 1, dh - 1, 1, 1,
                   (k == n - 1) ? 1 : 0, 0, 0);
        if (c == 0 && k < 256) begin
          obs_xi[k] = int'(bus.x_int);
          obs_xr[k] = int'(bus.x_rem);
          obs_yi[k] = int'(bus.y_int);
          obs_yr[k] = int'(bus.y_rem);
        end
        if (k * 8 + c == poke) begin
          set_cfg(3, 3, 2, 2);
          bus.start = 1'b1;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    end
    h_xi = sw - 1; h_xr = 0; h_yi = sh - 1; h_yr = 0; h_xd = dw - 1; h_yd = dh - 1;
    expect_all("done", 0, h_xi, h_xr, h_yi, h_yr, h_xd, h_yd, 0, 0, 0, 1, 0);
    if (start_on_done) begin
      set_cfg(4, 4, 4, 4);
      bus.start = 1'b1;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    expect_all("post", 0, h_xi, h_xr, h_yi, h_yr, h_xd, h_yd, 0, 0, 0, 0, 0);
  endtask

  // Rejected start: one cfg_err pulse, nothing else moves
  task automatic run_illegal(input int sw, input int sh, input int dw, input int dh);
    @(negedge clk);
    set_cfg(sw, sh, dw, dh);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    expect_all("rej", 0, h_xi, h_xr, h_yi, h_yr, h_xd, h_yd, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    expect_all("rej_after", 0, h_xi, h_xr, h_yi, h_yr, h_xd, h_yd, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset at phase 4 of a chosen slot
  task automatic run_reset_mid(input int sw, input int sh, input int dw, input int dh,
                               input int slot);
    @(negedge clk);
    set_cfg(sw, sh, dw, dh);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8 * slot + 4) begin
      @(posedge clk); #1;
    end
    check("rmid.cycle_cnt", int'(bus.cycle_cnt), 4);
    check("rmid.busy", int'(bus.busy), 1);
    #1 rst = 1'b1;
    #1;
    expect_all("rmid_async", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    h_xi = 0; h_xr = 0; h_yi = 0; h_yr = 0; h_xd = 0; h_yd = 0;
    repeat (8 * dw * dh + 16) begin
      @(posedge clk); #1;
      check("rmid_after.done", int'(bus.done), 0);
      check("rmid_after.busy", int'(bus.busy), 0);
    end
  endtask

  initial begin
    int sw, sh, dw, dh, lim;
    n_checks = 0;
    n_errors = 0;
    h_xi = 0; h_xr = 0; h_yi = 0; h_yr = 0; h_xd = 0; h_yd = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    set_cfg(0, 0, 0, 0);
    #12;
    expect_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Illegal configuration straight out of reset: outputs stay 0
    run_illegal(80, 2, 10, 2);

    // Upscale x
    run_frame(10, 2, 28, 2, -1, 1'b0);
    check("up.s1.x_int", obs_xi[1], 0);
    check("up.s1.x_rem", obs_xr[1], 9);
    check("up.s2.x_int", obs_xi[2], 0);
    check("up.s2.x_rem", obs_xr[2], 18);
    check("up.s3.x_int", obs_xi[3], 1);
    check("up.s3.x_rem", obs_xr[3], 0);
    check("up.s27.x_int", obs_xi[27], 9);
    check("up.s27.x_rem", obs_xr[27], 0);

    // Max downscale boundary: all 7 subtracts in one step
    run_frame(64, 2, 10, 2, -1, 1'b0);
    check("down.s1.x_int", obs_xi[1], 7);
    check("down.s1.x_rem", obs_xr[1], 0);

    // Raster wrap, start while busy, start during done
    run_frame(5, 5, 3, 2, 13, 1'b1);
    check("wrap.s3.x_int", obs_xi[3], 0);
    check("wrap.s3.x_rem", obs_xr[3], 0);
    check("wrap.s3.y_int", obs_yi[3], 4);
    check("wrap.s3.y_rem", obs_yr[3], 0);

    // Extra boundaries: widest destination, smallest legal ratio edge
    run_frame(127, 2, 127, 2, -1, 1'b0);
    run_frame(8, 8, 2, 2, -1, 1'b0);
    run_illegal(9, 2, 2, 2);
    run_illegal(1, 2, 2, 2);
    run_illegal(4, 4, 4, 1);

    // Reset mid-slot, then a fresh frame
    run_reset_mid(20, 9, 4, 3, 2);
    run_frame(20, 9, 4, 3, -1, 1'b0);

    // Random legal frames, interleaved with random illegal starts
    for (int t = 0; t < 6; t++) begin
      dw = $urandom_range(40, 2);
      dh = $urandom_range(6, 2);
      lim = 7 * (dw - 1) + 1;
      if (lim > 127) lim = 127;
      sw = $urandom_range(lim, 2);
      lim = 7 * (dh - 1) + 1;
      sh = $urandom_range(lim, 2);
      run_frame(sw, sh, dw, dh, int'($urandom_range(8 * dw * dh - 1, 0)), t[0]);
      dw = $urandom_range(18, 2);
      sw = $urandom_range(127, 7 * (dw - 1) + 2);
      run_illegal(sw, 2, dw, 2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
